spi_top: RTL and testbench
==========================

# spi_top

SPI mode-0 (CPOL=0, CPHA=0) slave with one-byte echo, operating fully in the system clock domain. Each byte received on MOSI is stored and returned, MSB first, on MISO during the next byte transfer. After reset, the first transfer returns 0x00. The block sits at the chip boundary: SCLK, CS_n and MOSI come asynchronously from an external master and are oversampled by `clk`.

## Interface
- No parameters. Data width is fixed at 8 bits, MSB first.
- clk  in  1  system clock; all logic is clocked on its rising edge. SCLK must be at most clk/4.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- CS_n  in  1  chip select, active low, asynchronous to clk.
- SCLK  in  1  SPI clock, idle low, asynchronous to clk.
- MOSI  in  1  master-to-slave data, asynchronous to clk.
- MISO  out  1  slave-to-master data; always driven, never tri-stated.

## Operation
- Input synchronization:
  - CS_n, SCLK and MOSI each pass through a two-flop synchronizer, giving stages s1 and s2.
  - SCLK edges are detected from the pair (s1, s2): a rise is s1=1, s2=0; a fall is s1=0, s2=1.
  - The edge action executes on the clk edge where s2 takes the new value.
  - Synchronized MOSI is taken from the same stage as the SCLK edge detect, so MOSI and SCLK stay aligned.
- State registers:
  - rx_shift[7:0]: receive shift register.
  - bit_cnt[2:0]: received-bit counter.
  - echo_reg[7:0]: last complete received byte.
  - tx_shift[7:0]: transmit shift register.
- MISO = tx_shift[7] in all states, registered or directly from the tx_shift flop.
- Idle (synchronized CS_n high):
  - bit_cnt is held at 0.
  - rx_shift keeps its value (don't care).
  - tx_shift is loaded from echo_reg every cycle.
  - SCLK edges are ignored.
- Active (synchronized CS_n low):
  - SCLK rise: rx_shift ← {rx_shift[6:0], MOSI}; bit_cnt increments and wraps 7→0.
  - On the rise that wraps bit_cnt from 7 to 0: echo_reg ← {rx_shift[6:0], MOSI}.
  - SCLK fall with bit_cnt≠0: tx_shift ← {tx_shift[6:0], 0}.
  - SCLK fall with bit_cnt=0 (a byte has just completed): tx_shift ← echo_reg. Longer frames therefore echo the previous byte within the same frame.
- CS_n deasserted mid-byte: the partial byte is discarded, echo_reg is unchanged, and bit_cnt returns to 0.
- CS_n rise coinciding with the final SCLK fall: the idle reload takes precedence. MISO then shows echo_reg[7].
- Reset (rst_n=0 at a clk edge):
  - Synchronizer flops are set to their idle values: CS_n=1, SCLK=0, MOSI=0.
  - rx_shift, bit_cnt, echo_reg and tx_shift are all cleared to 0.
  - MISO=0 on the following cycle.
  - Reset mid-transfer aborts the transfer; the next full byte after reset echoes as usual.

## Timing
- Latency from an SCLK pin edge to its action is 2 clk cycles: action on the second rising clk edge after the pin change, at most 20 ns at 100 MHz.
- MISO bit 7 must be valid no later than 2 clk cycles after CS_n falls; it is already valid while idle.
- Each subsequent MISO bit changes at most 2 clk cycles after an SCLK fall. It must be valid before the next SCLK rise, because the master samples MISO at that same edge.
- The master holds MOSI stable for at least 2 clk cycles before and after each SCLK rise.
- echo_reg updates 2 clk cycles after the 8th SCLK rise.
- Minimum CS_n high time between frames: 4 clk cycles.

## Test plan
- Reset, then a frame sending 0xA5 → MISO bits read 0x00; echo_reg=0xA5.
- Back-to-back frames 0x5A, 0xFF, 0x01, 0x00 (SCLK half-period 20 ns, clk 10 ns) → received bytes 0xA5, 0x5A, 0xFF, 0x01.
- Abort: send 3 bits of 0xF0 and raise CS_n, then send a full 0x3C frame → the 0x3C frame returns the previous echo unchanged. The next frame returns 0x3C.
- 16-bit frame in one CS_n low, sending 0x12 then 0x34, with the prior echo 0x77 → MISO reads 0x77, then 0x12.
- Assert rst_n low mid-frame after 0xC3 was echoed → MISO=0 one cycle later. The next frame returns 0x00.
- Idle check with CS_n high while toggling SCLK and MOSI → echo_reg, bit_cnt and MISO are unchanged.

Source files
------------

// File: rtl/spi_top.sv
// SPI mode-0 slave that echoes each received byte on the following transfer.
// All SPI pins are oversampled in the clk domain through two-flop synchronizers.
`timescale 1ns/1ps
module spi_top (
  input  logic clk,
  input  logic rst_n,
  input  logic CS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  logic       cs_s1, cs_s2;
  logic       sclk_s1, sclk_s2;
  logic       mosi_s1, mosi_s2;
  logic [7:0] rx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] echo_reg;
  logic [7:0] tx_shift;

  logic       sclk_rise;
  logic       sclk_fall;
  logic [7:0] rx_next;

  assign sclk_rise = sclk_s1 & ~sclk_s2;
  assign sclk_fall = ~sclk_s1 & sclk_s2;
  assign rx_next   = {rx_shift[6:0], mosi_s2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      rx_shift <= 8'h00;
      bit_cnt  <= 3'd0;
      echo_reg <= 8'h00;
      tx_shift <= 8'h00;
    end else begin
      cs_s1   <= CS_n;
      cs_s2   <= cs_s1;
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;

      // Idle reload wins over any SCLK fall seen on the same cycle as CS_n rising.
      if (cs_s2) begin
        bit_cnt  <= 3'd0;
        tx_shift <= echo_reg;
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            echo_reg <= rx_next;
        end
        if (sclk_fall) begin
          if (bit_cnt != 3'd0)
            tx_shift <= {tx_shift[6:0], 1'b0};
          else
            tx_shift <= echo_reg;
        end
      end
    end
  end

  assign MISO = tx_shift[7];

endmodule

// File: tb/tb_spi_top.sv
// Bench for spi_top: an SPI master driver plus a scoreboard of expected echo bytes.
`timescale 1ns/1ps
module tb_spi_top;

  localparam int HALF = 20;

  logic clk;
  logic rst_n;
  logic CS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  logic [7:0] exp_q[$];
  logic [7:0] echo_model;
  int vectors;
  int miscompares;

  spi_top dut (
    .clk  (clk),
    .rst_n(rst_n),
    .CS_n (CS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks (pin changes land 2 ns after a clk rise)
  task automatic frame_start();
    CS_n = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    CS_n = 1'b1;
    #(3 * HALF);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = d[i];
      #HALF;
      r[i] = MISO;
      SCLK = 1'b1;
      #HALF;
      SCLK = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    CS_n  = 1'b1;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (MISO !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_miso: got %b expected 0", MISO);
    end
    vectors++;
    if (dut.echo_reg !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_echo: got %h expected 00", dut.echo_reg);
    end
    vectors++;
    if (dut.bit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_bit_cnt: got %0d expected 0", dut.bit_cnt);
    end
    #1;
    rst_n = 1'b1;
    echo_model = 8'h00;
    #(2 * HALF);
  endtask

  task automatic test_first_frame();
    logic [7:0] r, e;
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(8'hA5, 8, r);
    frame_end();
    e = exp_q.pop_front();
    echo_model = 8'hA5;
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL first_frame_miso: got %h expected %h", r, e);
    end
    vectors++;
    if (dut.echo_reg !== echo_model) begin
      miscompares++;
      $display("FAIL first_frame_echo: got %h expected %h", dut.echo_reg, echo_model);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tx [4];
    logic [7:0] r, e;
    tx = '{8'h5A, 8'hFF, 8'h01, 8'h00};
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(echo_model);
      frame_start();
      send_bits(tx[k], 8, r);
      frame_end();
      echo_model = tx[k];
      e = exp_q.pop_front();
      vectors++;
      if (r !== e) begin
        miscompares++;
        $display("FAIL back_to_back frame %0d: got %h expected %h", k, r, e);
      end
    end
  endtask

  task automatic test_long_frame();
    logic [7:0] r, e;
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(8'h77, 8, r);
    frame_end();
    echo_model = 8'h77;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL long_prep: got %h expected %h", r, e);
    end
    frame_start();
    exp_q.push_back(echo_model);
    send_bits(8'h12, 8, r);
    echo_model = 8'h12;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL long_byte0: got %h expected %h", r, e);
    end
    exp_q.push_back(echo_model);
    send_bits(8'h34, 8, r);
    echo_model = 8'h34;
    frame_end();
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL long_byte1: got %h expected %h", r, e);
    end
    vectors++;
    if (dut.echo_reg !== echo_model) begin
      miscompares++;
      $display("FAIL long_echo: got %h expected %h", dut.echo_reg, echo_model);
    end
  endtask

  task automatic test_abort();
    logic [7:0] r, e;
    frame_start();
    send_bits(8'hF0, 3, r);
    frame_end();
    vectors++;
    if (dut.bit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_bit_cnt: got %0d expected 0", dut.bit_cnt);
    end
    vectors++;
    if (dut.echo_reg !== echo_model) begin
      miscompares++;
      $display("FAIL abort_echo: got %h expected %h", dut.echo_reg, echo_model);
    end
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(8'h3C, 8, r);
    frame_end();
    echo_model = 8'h3C;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL abort_next: got %h expected %h", r, e);
    end
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(8'hE7, 8, r);
    frame_end();
    echo_model = 8'hE7;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL abort_after: got %h expected %h", r, e);
    end
  endtask

  task automatic test_cs_race();
    logic [7:0] r, e;
    logic [7:0] d;
    d = 8'hB4;
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(d, 7, r);
    MOSI = d[0];
    #HALF;
    r[0] = MISO;
    SCLK = 1'b1;
    #HALF;
    SCLK = 1'b0;
    CS_n = 1'b1;
    #(3 * HALF);
    echo_model = d;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL cs_race_data: got %h expected %h", r, e);
    end
    vectors++;
    if (MISO !== echo_model[7]) begin
      miscompares++;
      $display("FAIL cs_race_miso: got %b expected %b", MISO, echo_model[7]);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 12; k++) begin
      SCLK = 1'($urandom_range(0, 1));
      MOSI = 1'($urandom_range(0, 1));
      #HALF;
    end
    SCLK = 1'b0;
    #(2 * HALF);
    vectors++;
    if (dut.echo_reg !== echo_model) begin
      miscompares++;
      $display("FAIL idle_echo: got %h expected %h", dut.echo_reg, echo_model);
    end
    vectors++;
    if (dut.bit_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL idle_bit_cnt: got %0d expected 0", dut.bit_cnt);
    end
    vectors++;
    if (MISO !== echo_model[7]) begin
      miscompares++;
      $display("FAIL idle_miso: got %b expected %b", MISO, echo_model[7]);
    end
  endtask

  task automatic test_random();
    logic [7:0] r, e, d;
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(echo_model);
      frame_start();
      send_bits(d, 8, r);
      frame_end();
      echo_model = d;
      e = exp_q.pop_front();
      vectors++;
      if (r !== e) begin
        miscompares++;
        $display("FAIL random frame %0d: got %h expected %h", k, r, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r, e;
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(8'hC3, 8, r);
    frame_end();
    echo_model = 8'hC3;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL mid_reset_prep: got %h expected %h", r, e);
    end
    frame_start();
    send_bits(8'h00, 1, r);
    vectors++;
    if (r[7] !== echo_model[7]) begin
      miscompares++;
      $display("FAIL mid_reset_bit7: got %b expected %b", r[7], echo_model[7]);
    end
    #HALF;
    vectors++;
    if (MISO !== echo_model[6]) begin
      miscompares++;
      $display("FAIL mid_reset_bit6: got %b expected %b", MISO, echo_model[6]);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (MISO !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_miso: got %b expected 0", MISO);
    end
    CS_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    echo_model = 8'h00;
    #(3 * HALF);
    vectors++;
    if (dut.echo_reg !== echo_model) begin
      miscompares++;
      $display("FAIL mid_reset_echo: got %h expected %h", dut.echo_reg, echo_model);
    end
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(8'h99, 8, r);
    frame_end();
    echo_model = 8'h99;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL after_reset_frame: got %h expected %h", r, e);
    end
    exp_q.push_back(echo_model);
    frame_start();
    send_bits(8'h66, 8, r);
    frame_end();
    echo_model = 8'h66;
    e = exp_q.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL after_reset_echo: got %h expected %h", r, e);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    echo_model  = 8'h00;
    rst_n = 1'b0;
    CS_n  = 1'b1;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_long_frame();
    test_abort();
    test_cs_race();
    test_idle();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
